slope_trigger_mc: RTL
=====================

// Module: slope_trigger_mc
// PURPOSE
//  Multi-channel slope (dV/dt) trigger for the axi_trigger IP.
//  Per channel: sliding derivative dv = x[n] - x[n-DT] over ADC samples, held in a circular history buffer.
//  Fires once on the first enabled channel whose slope crosses +/-USER_DV in the selected edge mode.
//  Tracks peak |dv| since arm. Sits between the ADC capture stage and the AXI-lite register bank.
// PARAMETERS
//  NUM_CH  4   number of ADC channels
//  ADC_W   12  ADC sample width, unsigned
//  MAX_DT  16  history depth per channel, power of 2 >= 4; DT range 1..MAX_DT-1
//  DV_W    32  width of USER_DV / MAX_DV, signed
// PORTS
//  CLK          in   1              system clock, rising edge
//  RST          in   1              asynchronous, active-low reset
//  MOD_ENABLED  in   1              0: synchronous clear to IDLE, same effect as reset
//  ARM          in   1              1-cycle pulse: latch config, clear status, start capture
//  CH_ENABLED   in   NUM_CH         per-channel trigger enable
//  ADC_VALID    in   1              one sample per channel present on ADC_DATA this cycle
//  ADC_DATA     in   NUM_CH*ADC_W   ch i at [i*ADC_W +: ADC_W]
//  USER_DV      in   DV_W           slope threshold, signed; values < 0 treated as 0
//  USER_DT      in   $clog2(MAX_DT) sample distance DT; 0 -> 1
//  EDGE_MODE    in   2              01 rising, 10 falling, 11 both, 00 never fire
//  TRIGGED      out  1              high from trigger until ARM / disable / reset
//  TRIG_EDGE    out  1              1 rising, 0 falling; valid while TRIGGED
//  TRIG_CH      out  $clog2(NUM_CH) index of the channel that fired
//  MAX_DV       out  DV_W           max |dv| over enabled channels since ARM, signed, >= 0
//  BUSY         out  1              high in FILL or RUN
// BEHAVIOUR
//  Reset values: all outputs 0, FSM = IDLE, buffer pointers 0. Buffer contents are don't-care.
//  FSM states:
//   IDLE -> FILL on ARM. ARM latches USER_DT, USER_DV, EDGE_MODE, CH_ENABLED, and clears MAX_DV, TRIGGED, TRIG_CH, TRIG_EDGE.
//   FILL -> RUN once DT valid samples have been written; no compares in FILL.
//   RUN  -> TRIGD on the first qualifying dv.
//   TRIGD holds all outputs until the next ARM (re-enters FILL) or MOD_ENABLED=0 (IDLE).
//  ARM in any state restarts FILL with the buffer fill count zeroed.
//  Config inputs are ignored between ARMs.
//  Buffer per channel, MAX_DT entries, shared write pointer wp, incremented mod MAX_DT on each ADC_VALID.
//   Read address: (wp - DT) mod MAX_DT, read before write in the same cycle.
//  Arithmetic: samples zero-extended to ADC_W+1 signed; dv is ADC_W+1 signed, no overflow possible.
//   |dv| and compares are sign-extended to DV_W.
//  Pipeline: sample accepted in cycle k -> dv registered in k+1 -> TRIGGED/TRIG_CH/MAX_DV updated in k+2.
//   Total latency 2 cycles; back-to-back ADC_VALID is supported.
//  Qualify (RUN only, channel enabled):
//   rising:  dv > USER_DV and EDGE_MODE[0]
//   falling: dv < -USER_DV and EDGE_MODE[1]
//   Comparisons are strict; dv == threshold never fires.
//  MAX_DV updates every RUN sample from enabled channels, including the sample that fires. It is frozen in TRIGD.
//  Simultaneous qualifying channels: lowest index wins.
//  Both edges cannot qualify on one channel unless USER_DV=0 and dv=0, which is impossible because of the strict compare.
//  ADC_VALID=0: pipeline holds, no compares, no pointer movement.
//  Reset or MOD_ENABLED=0 mid-FILL/RUN: immediate return to IDLE, all outputs cleared, in-flight pipeline data discarded.
// CONFIGURATION
//  SLOPE_TRIG_AUTO_REARM_EN defined:
//   TRIGD -> FILL automatically after MAX_DT further ADC_VALID samples (holdoff).
//   TRIGGED drops at that transition; MAX_DV keeps accumulating across re-arms until ARM.
//   Adds counter holdoff_cnt.
//  Not defined: TRIGD is sticky until ARM or disable; no holdoff logic synthesised.
// TESTING
//  Defaults, DT=4, DV=100, mode=11, ch0 only: ramp 0,50,100,...
//   -> dv=200 after FILL, TRIGGED=1, TRIG_EDGE=1, TRIG_CH=0, 2 cycles after the 5th sample.
//  Falling ramp 4000 down by 30/sample, DT=4, DV=100 -> dv=-120, TRIG_EDGE=0; same with mode=01 -> never fires, MAX_DV=120.
//  Ch1 and ch3 both cross on the same sample -> TRIG_CH=1.
//   Ch2 disabled but steeper -> MAX_DV excludes ch2.
//  Threshold boundary: dv exactly 100 with DV=100 -> no trigger; dv=101 -> trigger.
//   USER_DV=-5 behaves as 0.
//  RST low mid-RUN, and MOD_ENABLED low for 1 cycle -> all outputs 0, state IDLE.
//   Next ARM requires a full DT refill before any trigger.
//  With SLOPE_TRIG_AUTO_REARM_EN: after a trigger, 16 more valid samples -> TRIGGED=0 and BUSY=1.
//   Repeat ramp -> fires again.

Source files
------------

// File: rtl/slope_trigger_mc.sv
// slope_trigger_mc: multi-channel dV/dt trigger between the ADC capture stage and the AXI-lite register bank
// Optional feature macro: SLOPE_TRIG_AUTO_REARM_EN (automatic re-arm after a MAX_DT-sample holdoff)
// Ports:
//   CLK, RST      clock (rising edge), asynchronous active-low reset
//   MOD_ENABLED   0 = synchronous clear to IDLE
//   ARM           1-cycle pulse: latch config, clear status, restart FILL
//   CH_ENABLED    per-channel trigger enable (latched on ARM)
//   ADC_VALID     one sample per channel on ADC_DATA this cycle
//   ADC_DATA      channel i at [i*ADC_W +: ADC_W], unsigned
//   USER_DV       signed slope threshold, negative treated as 0 (latched on ARM)
//   USER_DT       sample distance, 0 treated as 1 (latched on ARM)
//   EDGE_MODE     bit0 rising, bit1 falling (latched on ARM)
//   TRIGGED       high from trigger until ARM / disable / reset
//   TRIG_EDGE     1 rising, 0 falling
//   TRIG_CH       index of the channel that fired
//   MAX_DV        peak |dv| over enabled channels since ARM
//   BUSY          high in FILL or RUN
module slope_trigger_mc #(
    parameter int NUM_CH = 4,
    parameter int ADC_W  = 12,
    parameter int MAX_DT = 16,
    parameter int DV_W   = 32
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        MOD_ENABLED,
    input  logic                        ARM,
    input  logic [NUM_CH-1:0]           CH_ENABLED,
    input  logic                        ADC_VALID,
    input  logic [NUM_CH*ADC_W-1:0]     ADC_DATA,
    input  logic [DV_W-1:0]             USER_DV,
    input  logic [$clog2(MAX_DT)-1:0]   USER_DT,
    input  logic [1:0]                  EDGE_MODE,
    output logic                        TRIGGED,
    output logic                        TRIG_EDGE,
    output logic [$clog2(NUM_CH)-1:0]   TRIG_CH,
    output logic [DV_W-1:0]             MAX_DV,
    output logic                        BUSY
);
    localparam int DT_W = $clog2(MAX_DT);
    localparam int CH_W = $clog2(NUM_CH);

    typedef enum logic [1:0] {IDLE, FILL, RUN, TRIGD} state_t;

    state_t                  state, state_nxt;
    logic [DT_W-1:0]         wp, rp, fill_cnt, cfg_dt;
    logic signed [DV_W-1:0]  cfg_dv;
    logic [1:0]              cfg_mode;
    logic [NUM_CH-1:0]       cfg_en;
    logic [ADC_W-1:0]        mem [NUM_CH][MAX_DT];
    logic signed [ADC_W:0]   dv_new [NUM_CH];
    logic signed [ADC_W:0]   dv_r [NUM_CH];
    logic signed [DV_W-1:0]  dv_x [NUM_CH];
    logic signed [DV_W-1:0]  mag [NUM_CH];
    logic [NUM_CH-1:0]       rise, fall;
    logic                    s1_valid, eval, hit, hit_edge;
    logic [CH_W-1:0]         hit_ch;
    logic [DV_W-1:0]         peak;
`ifdef SLOPE_TRIG_AUTO_REARM_EN
    logic [DT_W-1:0]         holdoff_cnt;
    logic                    holdoff_done;
`endif

    // The read address trails the shared write pointer by DT; it is read before this cycle's write lands
    assign rp = wp - cfg_dt;
    // A registered dv is only compared if it was accepted in RUN and we are still in RUN
    assign eval = s1_valid && state == RUN;
    assign TRIGGED = state == TRIGD;
    assign BUSY = state == FILL || state == RUN;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign dv_new[i] = $signed({1'b0, ADC_DATA[i*ADC_W +: ADC_W]}) - $signed({1'b0, mem[i][rp]});
        assign dv_x[i] = DV_W'(dv_r[i]);
        assign mag[i] = dv_x[i][DV_W-1] ? -dv_x[i] : dv_x[i];
        assign rise[i] = cfg_en[i] && cfg_mode[0] && dv_x[i] > cfg_dv;
        assign fall[i] = cfg_en[i] && cfg_mode[1] && dv_x[i] < -cfg_dv;
    end

    // Scan from the top so the lowest qualifying channel is the last one written
    always_comb begin
        hit = 1'b0;
        hit_edge = 1'b0;
        hit_ch = '0;
        peak = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (rise[i] || fall[i]) begin
                hit = 1'b1;
                hit_ch = CH_W'(i);
                hit_edge = rise[i];
            end
            if (cfg_en[i] && $unsigned(mag[i]) > peak) peak = $unsigned(mag[i]);
        end
    end

`ifdef SLOPE_TRIG_AUTO_REARM_EN
    assign holdoff_done = ADC_VALID && holdoff_cnt == DT_W'(MAX_DT - 1);
`endif

    always_comb begin
        state_nxt = state;
        if (!MOD_ENABLED) state_nxt = IDLE;
        else if (ARM) state_nxt = FILL;
        else case (state)
            FILL: if (ADC_VALID && fill_cnt == cfg_dt - DT_W'(1)) state_nxt = RUN;
            RUN: if (eval && hit) state_nxt = TRIGD;
`ifdef SLOPE_TRIG_AUTO_REARM_EN
            TRIGD: if (holdoff_done) state_nxt = FILL;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else state <= state_nxt;
    end

    // History buffer and first pipeline stage; contents need no reset because FILL rewrites them
    always_ff @(posedge CLK) begin
        if (ADC_VALID) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mem[i][wp] <= ADC_DATA[i*ADC_W +: ADC_W];
                dv_r[i] <= dv_new[i];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wp <= '0;
            fill_cnt <= '0;
            cfg_dt <= '0;
            cfg_dv <= '0;
            cfg_mode <= '0;
            cfg_en <= '0;
            s1_valid <= 1'b0;
            TRIG_EDGE <= 1'b0;
            TRIG_CH <= '0;
            MAX_DV <= '0;
        end else if (!MOD_ENABLED) begin
            wp <= '0;
            fill_cnt <= '0;
            s1_valid <= 1'b0;
            TRIG_EDGE <= 1'b0;
            TRIG_CH <= '0;
            MAX_DV <= '0;
        end else begin
            wp <= wp + DT_W'(ADC_VALID);
            s1_valid <= ADC_VALID && state == RUN && !ARM;
            fill_cnt <= (ARM || state != FILL) ? '0 : fill_cnt + DT_W'(ADC_VALID);
            if (ARM) begin
                cfg_dt <= (USER_DT == '0) ? DT_W'(1) : USER_DT;
                cfg_dv <= USER_DV[DV_W-1] ? '0 : $signed(USER_DV);
                cfg_mode <= EDGE_MODE;
                cfg_en <= CH_ENABLED;
                TRIG_EDGE <= 1'b0;
                TRIG_CH <= '0;
                MAX_DV <= '0;
            end else if (eval) begin
                if (peak > MAX_DV) MAX_DV <= peak;
                if (hit) begin
                    TRIG_CH <= hit_ch;
                    TRIG_EDGE <= hit_edge;
                end
            end
        end
    end

`ifdef SLOPE_TRIG_AUTO_REARM_EN
    // Counts samples seen while triggered; MAX_DV is deliberately left accumulating across re-arms
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) holdoff_cnt <= '0;
        else holdoff_cnt <= (!MOD_ENABLED || ARM || state != TRIGD) ? '0 : holdoff_cnt + DT_W'(ADC_VALID);
    end
`endif

endmodule
